// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline definitions for the MEM-stage data-memory access unit:
// FSM encodings, the rf_wesl load code, the timeout fill word and access helpers.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } mau_state_e;

  localparam logic [1:0]  RF_WESL_LOAD = 2'b01;
  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;
  localparam int unsigned WDOG_W       = 8;

  function automatic logic is_access(input logic       have_inst,
                                     input logic       dram_we,
                                     input logic [1:0] rf_wesl);
    return have_inst & (dram_we | (rf_wesl == RF_WESL_LOAD));
  endfunction

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/completion channel between the MEM-stage access unit
// (master) and the data memory (slave).
interface mem_access_unit_if;

  logic        dram_req;
  logic        dram_we;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic        dram_ack;
  logic [31:0] dram_rdata;

  modport master (
    output dram_req, dram_we, dram_addr, dram_wdata,
    input  dram_ack, dram_rdata
  );

  modport slave (
    input  dram_req, dram_we, dram_addr, dram_wdata,
    output dram_ack, dram_rdata
  );

endinterface

// File: rtl/mem_acc_watchdog.sv
// WAIT-state watchdog for the access unit; only exists when MEM_ACC_TIMEOUT_EN
// is defined. expired_o fires in the TIMEOUT_CYC-th consecutive enabled cycle.
`ifdef MEM_ACC_TIMEOUT_EN
module mem_acc_watchdog
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [WDOG_W-1:0] LAST_CNT = WDOG_W'(TIMEOUT_CYC - 1);

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;

  // Count consecutive enabled cycles; any gap restarts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i & (cnt_q == LAST_CNT);

endmodule
`endif

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: stalls the pipeline for one request per
// load/store. Optional WAIT watchdog selected by macro MEM_ACC_TIMEOUT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_have_inst,
  input  logic                     mem_dram_we,
  input  logic [1:0]               mem_rf_wesl,
  input  logic [31:0]              mem_aluC,
  input  logic [31:0]              mem_rd2,
  output logic                     stop,
  mem_access_unit_if.master        dram,
  output logic [31:0]              wb_rdata,
  output logic                     wb_rdata_vld,
  output logic                     acc_err
);

  mau_state_e  state_q, state_d;

  logic        acc_s, acc_ok_s, misalign_s, timeout_s, stop_s;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        load_q, load_d;
  logic [31:0] rdata_q, rdata_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;

  assign acc_s      = is_access(mem_have_inst, mem_dram_we, mem_rf_wesl);
  assign acc_ok_s   = acc_s & is_aligned(mem_aluC);
  assign misalign_s = acc_s & ~is_aligned(mem_aluC);

  // Nothing to build for an out-of-range limit; the named block marks it in the hierarchy.
  if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 255)) begin : g_timeout_cyc_out_of_range
  end

`ifdef MEM_ACC_TIMEOUT_EN
  mem_acc_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (state_q == ST_WAIT),
    .expired_o (timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE always returns to IDLE so a held instruction is not reissued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_ok_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (dram.dram_ack || timeout_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: combinational stall plus next values of the registered outputs.
  always_comb begin
    stop_s  = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    rdata_d = rdata_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc_ok_s) begin
          // Request fields are captured once so they stay frozen for the whole WAIT.
          stop_s  = 1'b1;
          req_d   = 1'b1;
          we_d    = mem_dram_we;
          addr_d  = mem_aluC;
          wdata_d = mem_dram_we ? mem_rd2 : 32'h0000_0000;
          load_d  = ~mem_dram_we;
        end else begin
          req_d = 1'b0;
          err_d = misalign_s;
        end
      end
      ST_WAIT: begin
        stop_s = 1'b1;
        if (dram.dram_ack) begin
          req_d = 1'b0;
          vld_d = load_q;
          if (load_q) begin
            rdata_d = dram.dram_rdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (timeout_s) begin
          req_d = 1'b0;
          err_d = 1'b1;
          vld_d = load_q;
          if (load_q) begin
            rdata_d = TIMEOUT_FILL;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      ST_DONE: begin
        req_d = 1'b0;
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

  // Registered outputs and captured request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      load_q  <= 1'b0;
      rdata_q <= 32'h0000_0000;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      rdata_q <= rdata_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  // Stall is gated by reset so it also reads 0 while rst_n is held low.
  assign stop            = stop_s & rst_n;
  assign dram.dram_req   = req_q;
  assign dram.dram_we    = we_q;
  assign dram.dram_addr  = addr_q;
  assign dram.dram_wdata = wdata_q;
  assign wb_rdata        = rdata_q;
  assign wb_rdata_vld    = vld_q;
  assign acc_err         = err_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 255, meaning watchdog limit in cycles (range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit, the pipeline clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-004 The block SHALL have inputs mem_have_inst (1), mem_dram_we (1), mem_rf_wesl (2), mem_aluC (32) and mem_rd2 (32): the MEM-stage instruction fields.
REQ-005 The block SHALL have output stop (1), the hold request to the EX/MEM and upstream pipeline registers.
REQ-006 The block SHALL have outputs dram_req (1), dram_we (1), dram_addr (32) and dram_wdata (32), the data-memory request channel.
REQ-007 The block SHALL have inputs dram_ack (1) and dram_rdata (32), the data-memory completion channel.
REQ-008 The block SHALL have outputs wb_rdata (32), wb_rdata_vld (1) and acc_err (1), carrying load data to WB and the error flag.

Function
REQ-009 The block SHALL treat a cycle as an access when mem_have_inst=1 and either mem_dram_we=1 (store) or mem_rf_wesl=2'b01 (load).
REQ-010 The block SHALL implement an FSM with states IDLE, WAIT and DONE.
REQ-011 In IDLE with an access present, the block SHALL assert stop combinationally and move to WAIT on the next edge; with no access, it SHALL stay in IDLE with stop=0.
REQ-012 In WAIT, the block SHALL drive dram_req=1, dram_addr=mem_aluC and dram_we=mem_dram_we, with dram_wdata=mem_rd2 on stores, and SHALL hold stop=1.
REQ-013 The block SHALL keep dram_addr, dram_we and dram_wdata stable while dram_req=1.
REQ-014 On dram_ack=1 in WAIT, the block SHALL register dram_rdata into wb_rdata (loads only) and move to DONE.
REQ-015 In DONE, the block SHALL drive stop=0 and dram_req=0, pulse wb_rdata_vld=1 for one cycle on a load, and return to IDLE, so that each instruction issues exactly one request.
REQ-016 Minimum stop duration SHALL be 2 cycles (IDLE and WAIT with ack in the first WAIT cycle); latency from access entry to release SHALL be 2 + (ack wait) cycles.
REQ-017 The block SHALL ignore dram_ack outside WAIT.
REQ-018 An access SHALL NOT be issued while in DONE, even if mem_* still shows one.
REQ-019 With mem_aluC[1:0]!=2'b00, the block SHALL issue no request, assert stop=0, and pulse acc_err for one cycle.

Reset
REQ-020 Asserting rst_n low SHALL force state=IDLE, stop=0, dram_req=0, dram_we=0, dram_addr=0, dram_wdata=0, wb_rdata=0, wb_rdata_vld=0, acc_err=0 and the watchdog count=0, including mid-WAIT; no request SHALL be issued in the first cycle after deassertion unless an access is present.

Configuration
REQ-021 With macro MEM_ACC_TIMEOUT_EN defined, an 8-bit watchdog SHALL count cycles in WAIT, and reaching TIMEOUT_CYC without ack SHALL drop dram_req, pulse acc_err, set wb_rdata=32'hDEAD_BEEF (loads) and move to DONE.
REQ-022 With MEM_ACC_TIMEOUT_EN undefined, no counter SHALL exist and WAIT SHALL be held indefinitely until ack.

Structure
REQ-023 FSM state encodings, the load encoding 2'b01 of rf_wesl and the timeout fill constant SHALL reside in the shared pipeline package.
REQ-024 The watchdog SHALL be an optional sub-module mem_acc_watchdog, instantiated only under MEM_ACC_TIMEOUT_EN.

Verification
REQ-025 Load with addr 0x100 and ack in the first WAIT cycle -> stop high for 2 cycles, wb_rdata=dram_rdata=0x12345678, wb_rdata_vld pulse in DONE.
REQ-026 Store with addr 0x200, data 0xCAFEF00D and ack after 5 cycles -> dram_req high 5 cycles with stable addr/wdata, dram_we=1, exactly one request issued.
REQ-027 Back-to-back load then store -> two distinct requests separated by a DONE cycle, with stop low only in DONE.
REQ-028 Load with addr 0x102 -> no dram_req, acc_err pulse, stop=0.
REQ-029 rst_n low during WAIT -> all outputs 0 asynchronously, state IDLE after release.
REQ-030 With MEM_ACC_TIMEOUT_EN, TIMEOUT_CYC=4 and no ack -> dram_req drops after 4 WAIT cycles, acc_err=1, wb_rdata=0xDEADBEEF.
